// File: rtl/mem_interface.sv
// Memory-access stage between the multi-cycle control unit and a unified
// instruction/data memory. It turns the control-unit strobes into a single
// req/ack bus transaction, holds the instruction register (IR) and memory
// data register (MDR), and stalls the control unit until the access ends.
module mem_interface #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstn,
  // Datapath sources
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] write_data,
  // Control-unit strobes
  input  logic              IorD,
  input  logic              ir_write,
  input  logic              mem_write,
  input  logic              mem_read,
  // Memory bus
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // Back to the control unit / datapath
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              bus_err
);

  // The counter only has to reach TIMEOUT-1, so TIMEOUT states suffice.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } kind_e;

  state_e            state_q;
  kind_e             kind_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] mdr_q;
  logic              bus_err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              req_any;
  kind_e             req_kind;
  logic [DATA_W-1:0] req_addr;
  logic              req_aligned;
  logic              abort;

  assign req_any     = ir_write | mem_write | mem_read;
  assign req_addr    = IorD ? alu_out : pc;
  assign req_aligned = (req_addr[1:0] == 2'b00);

  // Resolve simultaneous strobes: fetch beats store beats load.
  always_comb begin
    req_kind = KIND_LOAD;
    if (ir_write) begin
      req_kind = KIND_FETCH;
    end else if (mem_write) begin
      req_kind = KIND_STORE;
    end
  end

  // Abort fires in the last allowed BUSY cycle if the bus still has not acked;
  // an ack in that same cycle wins and the transaction completes normally.
  assign abort = (state_q == BUSY) && !mem_ack && (cnt_q == CNT_LAST);

  // Stall covers the request cycle and every BUSY cycle that will not finish;
  // misaligned requests fail immediately and never stall.
  assign stall = ((state_q == IDLE) && req_any && req_aligned)
               | ((state_q == BUSY) && !mem_ack && !abort);

  // Transaction FSM: latches the winning request, waits for ack or timeout,
  // and captures read data into IR or MDR on completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      kind_q      <= KIND_FETCH;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      instr_q     <= '0;
      mdr_q       <= '0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A stray ack while idle is ignored.
          if (req_any) begin
            if (!req_aligned) begin
              bus_err_q <= 1'b1;
            end else begin
              state_q     <= BUSY;
              kind_q      <= req_kind;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (req_kind == KIND_STORE);
              mem_addr_q  <= req_addr;
              mem_wdata_q <= write_data;
              cnt_q       <= '0;
            end
          end
        end
        BUSY: begin
          // Strobes are not looked at here; the latched access runs to the end.
          if (mem_ack) begin
            case (kind_q)
              KIND_FETCH: instr_q <= mem_rdata;
              KIND_LOAD:  mdr_q   <= mem_rdata;
              default:    ;
            endcase
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign mdr       = mdr_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed testbench for mem_interface: fetch, waited load, store, strobe
// priority, idle ack, misaligned access, timeout abort and mid-access reset.
module tb_mem_interface;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              rstn;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] write_data;
  logic              IorD;
  logic              ir_write;
  logic              mem_write;
  logic              mem_read;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [DATA_W-1:0] instr;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [DATA_W-1:0] mdr;
  logic              stall;
  logic              bus_err;

  int checks;
  int errors;

  mem_interface #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pc        (pc),
    .alu_out   (alu_out),
    .write_data(write_data),
    .IorD      (IorD),
    .ir_write  (ir_write),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .instr     (instr),
    .opcode    (opcode),
    .funct     (funct),
    .mdr       (mdr),
    .stall     (stall),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Complete a one-wait-free fetch; used only to set up IR contents.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    IorD = 1'b0; pc = addr; ir_write = 1'b1; mem_rdata = data; mem_ack = 1'b0;
    @(negedge clk);
    ir_write = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_req, mem_we, stall, bus_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {mem_req, mem_we, stall, bus_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, instr, mdr} !== 128'd0) begin
      errors++; $display("FAIL reset_regs: got %h expected 0", {mem_addr, mem_wdata, instr, mdr});
    end
    checks++;
    if ({opcode, funct} !== 12'd0) begin
      errors++; $display("FAIL reset_decode: got %h expected 000", {opcode, funct});
    end
    @(negedge clk);
    rstn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_fetch();
    @(negedge clk);
    IorD = 1'b0; pc = 32'h40; ir_write = 1'b1; mem_rdata = 32'h8C220004; mem_ack = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL fetch_req_stall: got %b expected 1", stall); end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_early: got %b expected 0", mem_req); end
    @(negedge clk);
    ir_write = 1'b0; mem_ack = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we} !== 2'b10) begin errors++; $display("FAIL fetch_bus: got req/we %b expected 10", {mem_req, mem_we}); end
    checks++;
    if (mem_addr !== 32'h40) begin errors++; $display("FAIL fetch_addr: got %h expected 00000040", mem_addr); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL fetch_ack_stall: got %b expected 0", stall); end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (instr !== 32'h8C220004) begin errors++; $display("FAIL fetch_instr: got %h expected 8c220004", instr); end
    checks++;
    if ({opcode, funct} !== {6'h23, 6'h04}) begin
      errors++; $display("FAIL fetch_decode: got op %h fn %h expected op 23 fn 04", opcode, funct);
    end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_drop: got %b expected 0", mem_req); end
    $display("test_fetch done");
  endtask

  task automatic test_load_wait();
    int stall_cycles;
    stall_cycles = 0;
    @(negedge clk);
    IorD = 1'b1; alu_out = 32'h100; mem_read = 1'b1; mem_rdata = 32'hDEADBEEF; mem_ack = 1'b0;
    #1;
    stall_cycles += int'(stall);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      // Disturb inputs while busy; the latched access must not change.
      mem_read = 1'b0; mem_write = 1'b1; alu_out = 32'h200 + 32'(i * 4);
      #1;
      stall_cycles += int'(stall);
      checks++;
      if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h100) begin
        errors++; $display("FAIL load_hold_%0d: got req/we %b addr %h expected 10 addr 00000100", i, {mem_req, mem_we}, mem_addr);
      end
    end
    @(negedge clk);
    mem_write = 1'b0; mem_ack = 1'b1;
    #1;
    stall_cycles += int'(stall);
    checks++;
    if (mem_addr !== 32'h100) begin errors++; $display("FAIL load_ack_addr: got %h expected 00000100", mem_addr); end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mdr !== 32'hDEADBEEF) begin errors++; $display("FAIL load_mdr: got %h expected deadbeef", mdr); end
    checks++;
    if (stall_cycles != 3) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 3", stall_cycles); end
    checks++;
    if (instr !== 32'h8C220004) begin errors++; $display("FAIL load_instr_kept: got %h expected 8c220004", instr); end
    $display("test_load_wait done");
  endtask

  task automatic test_store();
    @(negedge clk);
    IorD = 1'b1; alu_out = 32'h104; write_data = 32'h1234; mem_write = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_write = 1'b0; write_data = 32'h5555; mem_ack = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL store_bus: got req/we %b expected 11", {mem_req, mem_we}); end
    checks++;
    if (mem_wdata !== 32'h1234 || mem_addr !== 32'h104) begin
      errors++; $display("FAIL store_data: got addr %h wdata %h expected 00000104 00001234", mem_addr, mem_wdata);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (instr !== 32'h8C220004 || mdr !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_regs_kept: got instr %h mdr %h expected 8c220004 deadbeef", instr, mdr);
    end
    checks++;
    if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL store_drop: got %b expected 00", {mem_req, mem_we}); end
    $display("test_store done");
  endtask

  task automatic test_conflict();
    @(negedge clk);
    IorD = 1'b0; pc = 32'h80; alu_out = 32'h300; ir_write = 1'b1; mem_write = 1'b1; mem_rdata = 32'h00000020;
    @(negedge clk);
    ir_write = 1'b0; mem_write = 1'b0; mem_ack = 1'b1;
    #1;
    checks++;
    if (mem_addr !== 32'h80 || mem_we !== 1'b0) begin
      errors++; $display("FAIL conflict_bus: got addr %h we %b expected 00000080 0", mem_addr, mem_we);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (instr !== 32'h20 || {opcode, funct} !== {6'h00, 6'h20}) begin
      errors++; $display("FAIL conflict_instr: got %h expected 00000020", instr);
    end
    checks++;
    if (mdr !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_mdr: got %h expected deadbeef", mdr); end
    $display("test_conflict done");
  endtask

  task automatic test_idle_ack();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL idle_ack_stall: got %b expected 0", stall); end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (instr !== 32'h20 || mdr !== 32'hDEADBEEF || mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_ack_regs: got instr %h mdr %h req %b expected 00000020 deadbeef 0", instr, mdr, mem_req);
    end
    $display("test_idle_ack done");
  endtask

  task automatic test_misaligned();
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL misalign_pre_err: got %b expected 0", bus_err); end
    @(negedge clk);
    IorD = 1'b1; alu_out = 32'h102; mem_read = 1'b1; mem_rdata = 32'h77777777;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL misalign_stall: got %b expected 0", stall); end
    @(negedge clk);
    mem_read = 1'b0; mem_ack = 1'b1;
    #1;
    checks++;
    if (bus_err !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL misalign_err: got err %b req %b expected 1 0", bus_err, mem_req);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mdr !== 32'hDEADBEEF) begin errors++; $display("FAIL misalign_mdr: got %h expected deadbeef", mdr); end
    $display("test_misaligned done");
  endtask

  task automatic test_timeout();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (bus_err !== 1'b0 || instr !== 32'd0) begin
      errors++; $display("FAIL timeout_reset: got err %b instr %h expected 0 0", bus_err, instr);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    IorD = 1'b0; pc = 32'h44; ir_write = 1'b1; mem_rdata = 32'h12345678; mem_ack = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      ir_write = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b1 || stall !== (i < TIMEOUT - 1)) begin
        errors++; $display("FAIL timeout_busy_%0d: got req %b stall %b expected 1 %b", i, mem_req, stall, (i < TIMEOUT - 1));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || bus_err !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: got req %b err %b stall %b expected 0 1 0", mem_req, bus_err, stall);
    end
    checks++;
    if (instr !== 32'd0) begin errors++; $display("FAIL timeout_instr: got %h expected 0", instr); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_busy();
    do_fetch(32'h60, 32'h11111114);
    #1;
    checks++;
    if (instr !== 32'h11111114) begin errors++; $display("FAIL midrst_setup: got %h expected 11111114", instr); end
    @(negedge clk);
    IorD = 1'b0; pc = 32'h4C; ir_write = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    ir_write = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b expected 1", mem_req); end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr !== 32'd0 || bus_err !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got req %b instr %h err %b stall %b expected 0 0 0 0", mem_req, instr, bus_err, stall);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    IorD = 1'b0; pc = 32'h50; ir_write = 1'b1; mem_rdata = 32'hAC000008;
    @(negedge clk);
    ir_write = 1'b0; mem_ack = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h50) begin
      errors++; $display("FAIL midrst_refetch_bus: got req %b addr %h expected 1 00000050", mem_req, mem_addr);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (instr !== 32'hAC000008 || opcode !== 6'h2B) begin
      errors++; $display("FAIL midrst_refetch: got instr %h op %h expected ac000008 2b", instr, opcode);
    end
    $display("test_reset_mid_busy done");
  endtask

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0; pc = '0; alu_out = '0; write_data = '0; IorD = 1'b0;
    ir_write = 1'b0; mem_write = 1'b0; mem_read = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    test_reset();
    test_fetch();
    test_load_wait();
    test_store();
    test_conflict();
    test_idle_ack();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
